// File: rtl/mod_inverse_if.sv
// Request/response bundle for the modular inverse unit.
//   Start  - level request, held by the requester until Done or Fail
//   a, m   - operand and odd modulus, sampled when the request is taken
//   inv    - registered result, valid while Done is high
//   Done   - result valid (held)
//   Fail   - no inverse exists or operands are out of range (held)
//   Busy   - operation in progress
// master: requester side; slave: the inverse unit.
interface mod_inverse_if #(
    parameter int unsigned WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] inv;
    logic             Done;
    logic             Fail;
    logic             Busy;

    modport master (
        output Start,
        output a,
        output m,
        input  inv,
        input  Done,
        input  Fail,
        input  Busy
    );

    modport slave (
        input  Start,
        input  a,
        input  m,
        output inv,
        output Done,
        output Fail,
        output Busy
    );
endinterface

// File: rtl/mod_inverse.sv
// Iterative modular inverse: inv = a^-1 mod m via the binary extended Euclidean algorithm.
// One action is performed per Step cycle; a and m are sampled only when the request is taken.
// Ports:
//   Clk    - clock
//   Reset  - synchronous, active-high reset; aborts any operation without Done/Fail
//   bus    - mod_inverse_if slave modport (Start, a, m in; inv, Done, Fail, Busy out)
// All outputs come straight from registers.
module mod_inverse #(
    parameter int unsigned WIDTH = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    mod_inverse_if.slave  bus
);
    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StStep,
        StDone,
        StFail
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic [XW-1:0]    x1_q, x1_d;
    logic [XW-1:0]    x2_q, x2_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             busy_q, busy_d;

    logic [XW-1:0]    mr_ext;

    assign mr_ext = {1'b0, mr_q};

    // Halve x modulo mod: add the odd modulus first when x is odd so the shift is exact.
    // x < mod < 2^WIDTH, so x + mod fits in WIDTH+1 bits.
    function automatic logic [XW-1:0] halve_mod(input logic [XW-1:0] x,
                                                 input logic [XW-1:0] mod);
        logic [XW-1:0] sum;
        sum = x[0] ? (x + mod) : x;
        return sum >> 1;
    endfunction

    // (x - y) mod mod for x, y in [0, mod-1]; the wrap case stays below 2^(WIDTH+1).
    function automatic logic [XW-1:0] sub_mod(input logic [XW-1:0] x,
                                              input logic [XW-1:0] y,
                                              input logic [XW-1:0] mod);
        return (x >= y) ? (x - y) : (x + mod - y);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            u_q     <= '0;
            v_q     <= '0;
            mr_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            inv_q   <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            mr_q    <= mr_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        mr_d    = mr_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        inv_d   = inv_q;

        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    u_d     = bus.a;
                    v_d     = bus.m;
                    mr_d    = bus.m;
                    x1_d    = XW'(1);
                    x2_d    = '0;
                    state_d = StInit;
                end
            end
            StInit: begin
                if (!mr_q[0] || (mr_q < WIDTH'(3)) || (u_q == '0) || (u_q >= mr_q)) begin
                    inv_d   = '0;
                    state_d = StFail;
                end else begin
                    state_d = StStep;
                end
            end
            StStep: begin
                if (u_q == WIDTH'(1)) begin
                    inv_d   = x1_q[WIDTH-1:0];
                    state_d = StDone;
                end else if (v_q == WIDTH'(1)) begin
                    inv_d   = x2_q[WIDTH-1:0];
                    state_d = StDone;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    // Reached zero without hitting one: gcd(a, m) != 1.
                    inv_d   = '0;
                    state_d = StFail;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = halve_mod(x1_q, mr_ext);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = halve_mod(x2_q, mr_ext);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q, mr_ext);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q, mr_ext);
                end
            end
            StDone: begin
                if (!bus.Start) begin
                    state_d = StIdle;
                end
            end
            StFail: begin
                if (!bus.Start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flags are registered from the next state so they line up with it.
        done_d = (state_d == StDone);
        fail_d = (state_d == StFail);
        busy_d = (state_d == StInit) || (state_d == StStep);
    end

    assign bus.inv  = inv_q;
    assign bus.Done = done_q;
    assign bus.Fail = fail_q;
    assign bus.Busy = busy_q;
endmodule

// File: doc/mod_inverse.md
Name: mod_inverse

Overview:
- Iterative modular inverse unit. Given an operand a and an odd modulus m, it computes inv = a^-1 mod m using the binary extended Euclidean algorithm.
- It reverses the field-element path: the reduction block maps integers into residues mod m, and this block returns the multiplicative inverse of a residue.
- Used by the EC point-arithmetic controllers for affine division, one operation at a time.
- Start/Done level handshake, matching the other arithmetic blocks.

Parameters:
- WIDTH, 16, bit width of a, m and inv. The internal x1/x2 datapath is WIDTH+1 bits.

Ports:
- Clk  input  1  clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level request. Held high by the requester until Done or Fail is seen.
- a  input  WIDTH  operand. Must satisfy 0 < a < m, otherwise the operation fails.
- m  input  WIDTH  modulus. Must be odd and >= 3, otherwise the operation fails.
- inv  output  WIDTH  result, registered. Valid while Done=1.
- Done  output  1  result valid, held.
- Fail  output  1  no inverse or bad operands, held.
- Busy  output  1  high from the Init state through the Step states.

Behaviour:
- Reset: state Idle; inv=0, Done=0, Fail=0, Busy=0; internal registers u, v, x1, x2, mr cleared. Reset in any state aborts the operation in the next cycle, and no Done/Fail is produced.
- Sampling: a and m are sampled only on the Idle->Init transition. Changes to them afterwards have no effect.
- Idle: if Start=1, capture u=a, v=m, mr=m, x1=1, x2=0, then go to Init.
- Init (1 cycle): go to Fail_st if mr[0]=0, or mr<3, or u=0, or u>=mr. Otherwise go to Step.
- Step: exactly one action per cycle, evaluated in this priority order:
  1. u==1: inv<=x1, go to Done_st.
  2. v==1: inv<=x2, go to Done_st.
  3. u==0 or v==0: go to Fail_st (gcd != 1).
  4. u even: u<=u>>1; x1<=x1>>1 if x1 even, else (x1+mr)>>1.
  5. v even: same halving rule applied to v and x2.
  6. u>=v: u<=u-v; x1<=x1-x2 if x1>=x2, else x1+mr-x2.
  7. u<v: v<=v-u; x2<=x2-x1 if x2>=x1, else x2+mr-x1.
- Arithmetic and widths:
  - x1+mr and x1+mr-x2 are formed at WIDTH+1 bits, so there is no overflow.
  - x1 and x2 always remain in [0, mr-1].
  - inv takes the low WIDTH bits of the result.
- Done_st: Done=1, Busy=0, inv held. When Start=0, go to Idle and clear Done the next cycle; inv is held until the next capture.
- Fail_st: Fail=1, Busy=0, inv=0. Leaves for Idle when Start=0, same as Done_st.
- Back-to-back: Start held high through Done does not restart. Start must drop for at least 1 cycle before the next request.
- Latency: Start high in Idle, plus Init (1 cycle), plus Step cycles, then Done. Worst case is at most 3*WIDTH+3 cycles from Start to Done/Fail.
- a=1: Done two cycles after Start is captured (Init, then Step takes branch 1).
- Done and Fail are mutually exclusive and never both high.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- m=11, a=3, Start held -> Done=1, inv=4, Fail=0. Drop Start -> Done=0 one cycle later and Busy=0. Start then re-asserted with m=11, a=7 -> inv=8.
- m=65521, a=2 -> inv=32761 within 51 cycles. m=65521, a=65520 -> inv=65520.
- m=17, a=1 -> Done exactly 2 cycles after the Idle->Init transition, with inv=1.
- Bad operands, each -> Fail=1, Done=0, inv=0, Busy low after Fail:
  - a=0, m=11.
  - a=11, m=11.
  - m=10, a=3.
  - m=15, a=5 (gcd 5, detected in Step).
- Reset asserted mid-Step (m=65521, a=12345, 5 cycles after Start) -> all outputs 0 next cycle, no Done. Fresh request then completes with inv=a^-1 mod m verified by a*inv mod m == 1.
- Randomised: 1000 random odd m and random a in [1, m-1] -> either Done with a*inv mod m == 1, or Fail exactly when gcd(a,m) != 1. Latency never exceeds 3*WIDTH+3.
